// File: rtl/rs_alu_station.sv
// ALU reservation station: allocates up to two dispatch requests per cycle, wakes operands from the CDB,
// and issues the lowest-index operand-ready entry per cycle over a valid/ready handshake.
`ifndef DP_NUM_WIDTH
`define DP_NUM_WIDTH 2
`endif

module rs_alu_station #(
  parameter int ENTRY_NUM     = 8,
  parameter int ENTRY_WIDTH   = 3,
  parameter int TAG_WIDTH     = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int PAYLOAD_WIDTH = 48
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_req_1,
  input  logic                     i_req_2,
  input  logic [`DP_NUM_WIDTH-1:0] i_req_num,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload_1,
  input  logic [PAYLOAD_WIDTH-1:0] i_payload_2,
  input  logic [DATA_WIDTH-1:0]    i_src1_1,
  input  logic [DATA_WIDTH-1:0]    i_src2_1,
  input  logic                     i_src1_rdy_1,
  input  logic                     i_src2_rdy_1,
  input  logic [DATA_WIDTH-1:0]    i_src1_2,
  input  logic [DATA_WIDTH-1:0]    i_src2_2,
  input  logic                     i_src1_rdy_2,
  input  logic                     i_src2_rdy_2,
  input  logic                     i_cdb_vld,
  input  logic [TAG_WIDTH-1:0]     i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]    i_cdb_data,
  output logic [ENTRY_WIDTH:0]     o_free_num,
  output logic                     o_alloc_ok,
  output logic                     o_issue_vld,
  input  logic                     i_issue_rdy,
  output logic [PAYLOAD_WIDTH-1:0] o_issue_payload,
  output logic [DATA_WIDTH-1:0]    o_issue_src1,
  output logic [DATA_WIDTH-1:0]    o_issue_src2
);

  logic [ENTRY_NUM-1:0]     valid_q, valid_d;
  logic [ENTRY_NUM-1:0]     s1_rdy_q, s2_rdy_q;
  logic [DATA_WIDTH-1:0]    src1_q    [ENTRY_NUM];
  logic [DATA_WIDTH-1:0]    src2_q    [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0] payload_q [ENTRY_NUM];

  logic                   f1_found, f2_found, sel_found;
  logic [ENTRY_WIDTH-1:0] f1_idx, f2_idx, sel_idx;
  logic [ENTRY_WIDTH-1:0] wr1_idx, wr2_idx;
  logic                   we1, we2, issue_fire;

  // Incoming operands after same-cycle CDB bypass.
  logic [DATA_WIDTH-1:0]  in_s1_1, in_s2_1, in_s1_2, in_s2_2;
  logic                   in_r1_1, in_r2_1, in_r1_2, in_r2_2;

  function automatic logic tag_hit(input logic [DATA_WIDTH-1:0] v);
    return i_cdb_vld && (v[TAG_WIDTH-1:0] == i_cdb_tag);
  endfunction

  always_comb begin
    o_free_num = '0;
    f1_found   = 1'b0;
    f2_found   = 1'b0;
    f1_idx     = '0;
    f2_idx     = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!valid_q[i]) begin
        o_free_num = o_free_num + (ENTRY_WIDTH+1)'(1);
        if (!f1_found) begin
          f1_found = 1'b1;
          f1_idx   = ENTRY_WIDTH'(i);
        end else if (!f2_found) begin
          f2_found = 1'b1;
          f2_idx   = ENTRY_WIDTH'(i);
        end
      end
    end
  end

  assign o_alloc_ok = (o_free_num >= (ENTRY_WIDTH+1)'(i_req_num));

  // Slot 2 takes the lowest free entry when slot 1 is idle.
  always_comb begin
    we1     = i_req_1 && o_alloc_ok && f1_found;
    wr1_idx = f1_idx;
    if (i_req_1) begin
      we2     = i_req_2 && o_alloc_ok && f2_found;
      wr2_idx = f2_idx;
    end else begin
      we2     = i_req_2 && o_alloc_ok && f1_found;
      wr2_idx = f1_idx;
    end
  end

  always_comb begin
    in_r1_1 = i_src1_rdy_1 || tag_hit(i_src1_1);
    in_r2_1 = i_src2_rdy_1 || tag_hit(i_src2_1);
    in_r1_2 = i_src1_rdy_2 || tag_hit(i_src1_2);
    in_r2_2 = i_src2_rdy_2 || tag_hit(i_src2_2);
    in_s1_1 = i_src1_rdy_1 ? i_src1_1 : (tag_hit(i_src1_1) ? i_cdb_data : i_src1_1);
    in_s2_1 = i_src2_rdy_1 ? i_src2_1 : (tag_hit(i_src2_1) ? i_cdb_data : i_src2_1);
    in_s1_2 = i_src1_rdy_2 ? i_src1_2 : (tag_hit(i_src1_2) ? i_cdb_data : i_src1_2);
    in_s2_2 = i_src2_rdy_2 ? i_src2_2 : (tag_hit(i_src2_2) ? i_cdb_data : i_src2_2);
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (!sel_found && valid_q[i] && s1_rdy_q[i] && s2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = ENTRY_WIDTH'(i);
      end
    end
  end

  assign o_issue_vld     = sel_found && !i_flush;
  assign o_issue_payload = o_issue_vld ? payload_q[sel_idx] : '0;
  assign o_issue_src1    = o_issue_vld ? src1_q[sel_idx]    : '0;
  assign o_issue_src2    = o_issue_vld ? src2_q[sel_idx]    : '0;
  assign issue_fire      = o_issue_vld && i_issue_rdy;

  // An issued entry is still valid this cycle, so it can never be a write target.
  always_comb begin
    valid_d = valid_q;
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (we1)        valid_d[wr1_idx] = 1'b1;
    if (we2)        valid_d[wr2_idx] = 1'b1;
    if (i_flush)    valid_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (valid_q[i] && !s1_rdy_q[i] && tag_hit(src1_q[i])) begin
        src1_q[i]   <= i_cdb_data;
        s1_rdy_q[i] <= 1'b1;
      end
      if (valid_q[i] && !s2_rdy_q[i] && tag_hit(src2_q[i])) begin
        src2_q[i]   <= i_cdb_data;
        s2_rdy_q[i] <= 1'b1;
      end
      if (we1 && (wr1_idx == ENTRY_WIDTH'(i))) begin
        payload_q[i] <= i_payload_1;
        src1_q[i]    <= in_s1_1;
        src2_q[i]    <= in_s2_1;
        s1_rdy_q[i]  <= in_r1_1;
        s2_rdy_q[i]  <= in_r2_1;
      end
      if (we2 && (wr2_idx == ENTRY_WIDTH'(i))) begin
        payload_q[i] <= i_payload_2;
        src1_q[i]    <= in_s1_2;
        src2_q[i]    <= in_s2_2;
        s1_rdy_q[i]  <= in_r1_2;
        s2_rdy_q[i]  <= in_r2_2;
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_station.sv
// Bench for rs_alu_station: directed scenarios followed by random traffic, checked against an entry-level model.
module tb_rs_alu_station;
  localparam int N = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_req_1 = 1'b0, i_req_2 = 1'b0;
  logic [1:0]  i_req_num = '0;
  logic [47:0] i_payload_1 = '0, i_payload_2 = '0;
  logic [31:0] i_src1_1 = '0, i_src2_1 = '0, i_src1_2 = '0, i_src2_2 = '0;
  logic        i_src1_rdy_1 = 1'b0, i_src2_rdy_1 = 1'b0, i_src1_rdy_2 = 1'b0, i_src2_rdy_2 = 1'b0;
  logic        i_cdb_vld = 1'b0;
  logic [5:0]  i_cdb_tag = '0;
  logic [31:0] i_cdb_data = '0;
  logic [3:0]  o_free_num;
  logic        o_alloc_ok, o_issue_vld;
  logic        i_issue_rdy = 1'b0;
  logic [47:0] o_issue_payload;
  logic [31:0] o_issue_src1, o_issue_src2;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: one record per entry.
  bit          m_v [N];
  bit          m_r1[N];
  bit          m_r2[N];
  logic [31:0] m_s1[N];
  logic [31:0] m_s2[N];
  logic [47:0] m_p [N];

  rs_alu_station dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_req_1(i_req_1), .i_req_2(i_req_2), .i_req_num(i_req_num),
    .i_payload_1(i_payload_1), .i_payload_2(i_payload_2),
    .i_src1_1(i_src1_1), .i_src2_1(i_src2_1), .i_src1_rdy_1(i_src1_rdy_1), .i_src2_rdy_1(i_src2_rdy_1),
    .i_src1_2(i_src1_2), .i_src2_2(i_src2_2), .i_src1_rdy_2(i_src1_rdy_2), .i_src2_rdy_2(i_src2_rdy_2),
    .i_cdb_vld(i_cdb_vld), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
    .o_free_num(o_free_num), .o_alloc_ok(o_alloc_ok), .o_issue_vld(o_issue_vld),
    .i_issue_rdy(i_issue_rdy), .o_issue_payload(o_issue_payload),
    .o_issue_src1(o_issue_src1), .o_issue_src2(o_issue_src2)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free();
    int c = 0;
    for (int i = 0; i < N; i++) if (!m_v[i]) c++;
    return c;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < N; i++) if (m_v[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  function automatic bit hit(input logic [31:0] v);
    return i_cdb_vld && (v[5:0] == i_cdb_tag);
  endfunction

  task automatic check_outputs();
    int  sel = m_sel();
    bit  vld = (sel >= 0) && !i_flush;
    chk("free_num", 64'(o_free_num), 64'(m_free()));
    chk("alloc_ok", 64'(o_alloc_ok), 64'(m_free() >= int'(i_req_num)));
    chk("issue_vld", 64'(o_issue_vld), 64'(vld));
    chk("issue_payload", 64'(o_issue_payload), vld ? 64'(m_p[sel]) : 64'd0);
    chk("issue_src1", 64'(o_issue_src1), vld ? 64'(m_s1[sel]) : 64'd0);
    chk("issue_src2", 64'(o_issue_src2), vld ? 64'(m_s2[sel]) : 64'd0);
  endtask

  task automatic m_write(input int e, input logic [47:0] p, input logic [31:0] a, input logic ra,
                         input logic [31:0] b, input logic rb);
    m_v[e]  = 1;
    m_p[e]  = p;
    m_r1[e] = ra || hit(a);
    m_s1[e] = (!ra && hit(a)) ? i_cdb_data : a;
    m_r2[e] = rb || hit(b);
    m_s2[e] = (!rb && hit(b)) ? i_cdb_data : b;
  endtask

  task automatic model_step();
    int sel = m_sel();
    int fq[$];
    bit ok = m_free() >= int'(i_req_num);
    if (i_flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      return;
    end
    for (int i = 0; i < N; i++) if (!m_v[i]) fq.push_back(i);
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && !m_r1[i] && hit(m_s1[i])) begin m_s1[i] = i_cdb_data; m_r1[i] = 1; end
      if (m_v[i] && !m_r2[i] && hit(m_s2[i])) begin m_s2[i] = i_cdb_data; m_r2[i] = 1; end
    end
    if (sel >= 0 && i_issue_rdy) m_v[sel] = 0;
    if (ok && i_req_1 && fq.size() > 0)
      m_write(fq.pop_front(), i_payload_1, i_src1_1, i_src1_rdy_1, i_src2_1, i_src2_rdy_1);
    if (ok && i_req_2 && fq.size() > 0)
      m_write(fq.pop_front(), i_payload_2, i_src1_2, i_src1_rdy_2, i_src2_2, i_src2_rdy_2);
  endtask

  task automatic tick();
    #3;
    check_outputs();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_req_1 = 0; i_req_2 = 0; i_req_num = 0;
    i_cdb_vld = 0; i_flush = 0;
  endtask

  task automatic slot1(input logic [47:0] p, input logic [31:0] a, input logic ra,
                       input logic [31:0] b, input logic rb);
    i_req_1 = 1; i_payload_1 = p; i_src1_1 = a; i_src1_rdy_1 = ra; i_src2_1 = b; i_src2_rdy_1 = rb;
    i_req_num = 2'(int'(i_req_1) + int'(i_req_2));
  endtask

  task automatic slot2(input logic [47:0] p, input logic [31:0] a, input logic ra,
                       input logic [31:0] b, input logic rb);
    i_req_2 = 1; i_payload_2 = p; i_src1_2 = a; i_src1_rdy_2 = ra; i_src2_2 = b; i_src2_rdy_2 = rb;
    i_req_num = 2'(int'(i_req_1) + int'(i_req_2));
  endtask

  task automatic apply_reset();
    i_rst = 1;
    #2;
    chk("rst_free", 64'(o_free_num), 64'd8);
    chk("rst_alloc_ok", 64'(o_alloc_ok), 64'd1);
    chk("rst_issue_vld", 64'(o_issue_vld), 64'd0);
    chk("rst_payload", 64'(o_issue_payload), 64'd0);
    chk("rst_src1", 64'(o_issue_src1), 64'd0);
    chk("rst_src2", 64'(o_issue_src2), 64'd0);
    for (int i = 0; i < N; i++) m_v[i] = 0;
    i_rst = 0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic rand_op(output logic [31:0] v, output logic r);
    r = 1'($urandom_range(0, 1));
    if (r) v = $urandom();
    else   v = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
  endtask

  initial begin
    logic [31:0] a, b, c, d;
    logic        ra, rb, rc, rd;
    #1;
    idle();
    apply_reset();

    // Two ready requests drain in order, one per cycle.
    i_issue_rdy = 1;
    slot1(48'hA0, 32'h1, 1, 32'h2, 1);
    slot2(48'hB1, 32'h3, 1, 32'h4, 1);
    tick();
    idle(); #1;
    chk("t1_free6", 64'(o_free_num), 64'd6);
    chk("t1_issue_e0", 64'(o_issue_payload), 64'hA0);
    tick();
    chk("t1_issue_e1", 64'(o_issue_payload), 64'hB1);
    tick();
    chk("t1_free8", 64'(o_free_num), 64'd8);

    // Fill 7 entries with waiting operands; a 2-request is refused, a 1-request fits.
    for (int k = 0; k < 3; k++) begin
      slot1(48'(16 + 2 * k), 32'd40, 0, 32'd41, 0);
      slot2(48'(17 + 2 * k), 32'd40, 0, 32'd41, 0);
      tick();
      idle();
    end
    slot1(48'h22, 32'd40, 0, 32'd41, 0);
    tick();
    idle();
    slot1(48'h30, 32'd40, 0, 32'd41, 0);
    slot2(48'h31, 32'd40, 0, 32'd41, 0);
    #1;
    chk("t2_alloc_refused", 64'(o_alloc_ok), 64'd0);
    tick();
    idle(); #1;
    chk("t2_free_stays1", 64'(o_free_num), 64'd1);
    slot1(48'h32, 32'd40, 0, 32'd41, 0);
    tick();
    idle(); #1;
    chk("t2_free0", 64'(o_free_num), 64'd0);
    i_flush = 1;
    tick();
    idle();

    // Two-step wakeup through the CDB.
    slot1(48'h55, 32'd5, 0, 32'd9, 0);
    tick();
    idle();
    i_cdb_vld = 1; i_cdb_tag = 6'd5; i_cdb_data = 32'h11;
    tick();
    idle(); #1;
    chk("t3_wait_tag9", 64'(o_issue_vld), 64'd0);
    i_cdb_vld = 1; i_cdb_tag = 6'd9; i_cdb_data = 32'h22;
    tick();
    idle(); #1;
    chk("t3_vld", 64'(o_issue_vld), 64'd1);
    chk("t3_src1", 64'(o_issue_src1), 64'h11);
    chk("t3_src2", 64'(o_issue_src2), 64'h22);
    tick();

    // Allocation bypass from a same-cycle CDB broadcast.
    slot1(48'h66, 32'd3, 0, 32'd7, 1);
    i_cdb_vld = 1; i_cdb_tag = 6'd3; i_cdb_data = 32'hABCD;
    tick();
    idle(); #1;
    chk("t4_vld", 64'(o_issue_vld), 64'd1);
    chk("t4_src1", 64'(o_issue_src1), 64'hABCD);
    tick();

    // Ready entries 2 and 5 under backpressure.
    i_issue_rdy = 0;
    slot1(48'h70, 32'd50, 0, 32'd50, 0); slot2(48'h71, 32'd50, 0, 32'd50, 0); tick(); idle();
    slot1(48'h72, 32'hA, 1, 32'hB, 1);   slot2(48'h73, 32'd50, 0, 32'd50, 0); tick(); idle();
    slot1(48'h74, 32'd50, 0, 32'd50, 0); slot2(48'h75, 32'hC, 1, 32'hD, 1);   tick(); idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_hold_e2", 64'(o_issue_payload), 64'h72);
      tick();
    end
    i_issue_rdy = 1; #1;
    chk("t5_issue_e2", 64'(o_issue_payload), 64'h72);
    tick();
    chk("t5_issue_e5", 64'(o_issue_payload), 64'h75);
    tick();
    i_issue_rdy = 0;
    slot1(48'h76, 32'hE, 1, 32'hF, 1);
    tick();
    idle();

    // Flush with a concurrent request and CDB hit.
    i_flush = 1;
    slot1(48'h77, 32'h1, 1, 32'h2, 1);
    i_cdb_vld = 1; i_cdb_tag = 6'd50; i_cdb_data = 32'h99;
    #1;
    chk("t6_flush_vld", 64'(o_issue_vld), 64'd0);
    tick();
    idle(); #1;
    chk("t6_flush_free", 64'(o_free_num), 64'd8);

    // Asynchronous reset mid-operation.
    slot1(48'h80, 32'h1, 1, 32'h2, 1);
    slot2(48'h81, 32'd12, 0, 32'h2, 1);
    tick();
    idle();
    apply_reset();

    // Random traffic.
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      rand_op(a, ra); rand_op(b, rb); rand_op(c, rc); rand_op(d, rd);
      if ($urandom_range(0, 2) != 0) slot1(48'($urandom()) ^ 48'(cyc << 32), a, ra, b, rb);
      if ($urandom_range(0, 2) != 0) slot2(48'($urandom()) ^ 48'(cyc << 33), c, rc, d, rd);
      i_cdb_vld   = 1'($urandom_range(0, 1));
      i_cdb_tag   = 6'($urandom_range(0, 7));
      i_cdb_data  = $urandom();
      i_issue_rdy = ($urandom_range(0, 9) < 7);
      i_flush     = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
